// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared states, opcode classes and opcode values for the multi-cycle control unit
package ctrl_pkg;
  typedef enum logic [2:0] {START, FETCH, DECODE, EXEC, MEM, WB, FAULT} state_e;
  typedef enum logic [2:0] {CL_R, CL_J, CL_BEQ, CL_IMM, CL_LW, CL_SW, CL_ILL} op_class_e;
  localparam int OP_RTYPE = 0;
  localparam int OP_J     = 2;
  localparam int OP_BEQ   = 4;
  localparam int OP_ADDI  = 8;
  localparam int OP_SLTI  = 10;
  localparam int OP_ANDI  = 12;
  localparam int OP_ORI   = 13;
  localparam int OP_XORI  = 14;
  localparam int OP_LW    = 35;
  localparam int OP_SW    = 43;
endpackage

// File: rtl/main_decoder.sv
// main_decoder: combinational opcode decode into static datapath selects and an instruction class
//   opCode in  : opcode field
//   outReg out : destination select (1=rd, 0=rt)
//   i2     out : ALU operand 2 select (1=immediate)
//   regI   out : write-back source select (1=memory)
//   legal  out : opcode is supported
//   cls    out : instruction class steering the control FSM
module main_decoder
  import ctrl_pkg::*;
#(
  parameter int OPCODE_W = 6
) (
  input  logic [OPCODE_W-1:0] opCode,
  output logic                outReg,
  output logic                i2,
  output logic                regI,
  output logic                legal,
  output op_class_e           cls
);
  logic [31:0] op;
  assign op = 32'(opCode);
  always_comb begin
    cls = op == OP_RTYPE ? CL_R :
          op == OP_J     ? CL_J :
          op == OP_BEQ   ? CL_BEQ :
          (op == OP_ADDI || op == OP_SLTI || op == OP_ANDI || op == OP_ORI || op == OP_XORI) ? CL_IMM :
          op == OP_LW    ? CL_LW :
          op == OP_SW    ? CL_SW : CL_ILL;
  end
  assign outReg = cls inside {CL_R, CL_BEQ, CL_IMM, CL_SW};
  assign i2     = cls inside {CL_IMM, CL_LW, CL_SW, CL_J};
  assign regI   = cls inside {CL_LW, CL_J};
  assign legal  = cls != CL_ILL;
endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle MIPS32 main control FSM (fetch/decode/exec/mem/wb with memory ready handshake)
//   clk, rst (async, active-high)
//   opCode, zero, memReady           : instruction opcode, ALU zero flag, memory access done
//   imRd, irW, pcW, wP, mrP, mwP     : fetch request, IR/PC/regfile writes, data memory read/write
//   branch, illegal                  : branch compare cycle, unsupported-opcode pulse
//   outReg, i2, regI                 : static datapath selects held from the last decoded opcode
//   fault                            : sticky memory watchdog trip
//   Define CTRL_MEM_WATCHDOG_EN to enable the MEM_TIMEOUT memory watchdog; otherwise waits are unbounded.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int OPCODE_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [OPCODE_W-1:0] opCode,
  input  logic                zero,
  input  logic                memReady,
  output logic                imRd,
  output logic                irW,
  output logic                pcW,
  output logic                outReg,
  output logic                i2,
  output logic                regI,
  output logic                wP,
  output logic                mrP,
  output logic                mwP,
  output logic                branch,
  output logic                illegal,
  output logic                fault
);
  state_e state_q, state_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  op_class_e cls_q, cls_in;
  logic legal_in, sel_or, sel_i2, sel_ri, timeout;
  main_decoder #(.OPCODE_W(OPCODE_W)) u_dec_q (
    .opCode(op_q), .outReg(sel_or), .i2(sel_i2), .regI(sel_ri), .legal(), .cls(cls_q)
  );
  main_decoder #(.OPCODE_W(OPCODE_W)) u_dec_in (
    .opCode(opCode), .outReg(), .i2(), .regI(), .legal(legal_in), .cls(cls_in)
  );
  // opReg resets to R-type, so the selects are masked in START to keep every output low
  assign outReg = state_q != START && sel_or;
  assign i2     = state_q != START && sel_i2;
  assign regI   = state_q != START && sel_ri;
`ifdef CTRL_MEM_WATCHDOG_EN
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic waiting;
  // FETCH/MEM are left only on memReady, so clearing whenever not waiting also clears on entry
  assign waiting = (state_q == FETCH || state_q == MEM) && !memReady;
  assign timeout = waiting && cnt_q == CW'(MEM_TIMEOUT - 1);
  assign cnt_d   = waiting ? cnt_q + CW'(1) : '0;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  assign fault = state_q == FAULT;
`else
  assign timeout = 1'b0;
  assign fault   = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= START;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    imRd    = 1'b0;
    irW     = 1'b0;
    pcW     = 1'b0;
    wP      = 1'b0;
    mrP     = 1'b0;
    mwP     = 1'b0;
    branch  = 1'b0;
    illegal = 1'b0;
    case (state_q)
      START: state_d = FETCH;
      FETCH: begin
        imRd    = 1'b1;
        irW     = memReady;
        pcW     = memReady;
        state_d = timeout ? FAULT : memReady ? DECODE : FETCH;
      end
      DECODE: begin
        op_d    = opCode;
        pcW     = cls_in == CL_J;
        illegal = !legal_in;
        state_d = (cls_in == CL_J || !legal_in) ? FETCH : EXEC;
      end
      EXEC: begin
        branch  = cls_q == CL_BEQ;
        pcW     = branch && zero;
        state_d = branch ? FETCH : (cls_q == CL_LW || cls_q == CL_SW) ? MEM : WB;
      end
      MEM: begin
        mrP     = cls_q == CL_LW;
        mwP     = cls_q == CL_SW;
        state_d = timeout ? FAULT : !memReady ? MEM : mrP ? WB : FETCH;
      end
      WB: begin
        wP      = 1'b1;
        state_d = FETCH;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven per-cycle check of the multi-cycle control FSM plus wait/watchdog sequences
module tb_multicycle_control;
  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, memReady = 1'b0;
  logic [5:0] opCode = '0;
  logic imRd, irW, pcW, outReg, i2, regI, wP, mrP, mwP, branch, illegal, fault;
  int total = 0, bad = 0;
  always #5 clk = ~clk;
  multicycle_control #(.MEM_TIMEOUT(4), .OPCODE_W(6)) dut (
    .clk(clk), .rst(rst), .opCode(opCode), .zero(zero), .memReady(memReady),
    .imRd(imRd), .irW(irW), .pcW(pcW), .outReg(outReg), .i2(i2), .regI(regI),
    .wP(wP), .mrP(mrP), .mwP(mwP), .branch(branch), .illegal(illegal), .fault(fault)
  );
  // enable vector order: imRd irW pcW wP mrP mwP branch illegal fault
  localparam logic [8:0] E_NONE = 9'b000000000, E_FETCH = 9'b111000000, E_WAIT = 9'b100000000,
                         E_WB = 9'b000100000, E_RD = 9'b000010000, E_WR = 9'b000001000,
                         E_BR = 9'b000000100, E_BRT = 9'b001000100, E_J = 9'b001000000,
                         E_ILL = 9'b000000010, E_FLT = 9'b000000001;
  // select vector order: outReg i2 regI
  localparam logic [2:0] S_0 = 3'b000, S_R = 3'b100, S_I = 3'b110, S_LJ = 3'b011;
  typedef struct {
    logic       r;
    logic [5:0] op;
    logic       z;
    logic       mr;
    logic [8:0] en;
    logic [2:0] sel;
  } vec_t;
  vec_t tv[$];
  function automatic void add(input logic r, input logic [5:0] op, input logic z, input logic mr,
                              input logic [8:0] en, input logic [2:0] sel);
    tv.push_back('{r, op, z, mr, en, sel});
  endfunction
  task automatic check(input string name, input logic [8:0] en, input logic [2:0] sel);
    logic [8:0] ea;
    logic [2:0] sa;
    ea = {imRd, irW, pcW, wP, mrP, mwP, branch, illegal, fault};
    sa = {outReg, i2, regI};
    total++;
    if (ea !== en || sa !== sel) begin
      bad++;
      $display("FAIL %s: en=%b sel=%b, want en=%b sel=%b", name, ea, sa, en, sel);
    end
  endtask
  task automatic step(input string name, input logic r, input logic [5:0] op, input logic z,
                      input logic mr, input logic [8:0] en, input logic [2:0] sel);
    rst = r; opCode = op; zero = z; memReady = mr;
    #3;
    check(name, en, sel);
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1;
    @(posedge clk);
    #1;
    add(1, 0, 0, 1, E_NONE, S_0);
    add(0, 0, 0, 1, E_NONE, S_0);
    add(0, 0, 0, 1, E_FETCH, S_R);
    add(0, 0, 0, 1, E_NONE, S_R);
    add(0, 0, 0, 1, E_NONE, S_R);
    add(0, 0, 0, 1, E_WB, S_R);
    add(0, 4, 1, 1, E_FETCH, S_R);
    add(0, 4, 1, 1, E_NONE, S_R);
    add(0, 4, 1, 1, E_BRT, S_R);
    add(0, 4, 0, 1, E_FETCH, S_R);
    add(0, 4, 0, 1, E_NONE, S_R);
    add(0, 4, 0, 1, E_BR, S_R);
    add(0, 2, 0, 1, E_FETCH, S_R);
    add(0, 2, 0, 1, E_J, S_R);
    add(0, 63, 0, 1, E_FETCH, S_LJ);
    add(0, 63, 0, 1, E_ILL, S_LJ);
    add(0, 43, 0, 1, E_FETCH, S_0);
    add(0, 43, 0, 1, E_NONE, S_0);
    add(0, 43, 0, 1, E_NONE, S_I);
    add(0, 43, 0, 1, E_WR, S_I);
    add(0, 35, 0, 0, E_WAIT, S_I);
    add(0, 35, 0, 1, E_FETCH, S_I);
    add(0, 35, 0, 1, E_NONE, S_I);
    add(0, 35, 0, 1, E_NONE, S_LJ);
    add(0, 35, 0, 0, E_RD, S_LJ);
    add(0, 35, 0, 0, E_RD, S_LJ);
    add(0, 35, 0, 0, E_RD, S_LJ);
    add(0, 35, 0, 1, E_RD, S_LJ);
    add(0, 35, 0, 1, E_WB, S_LJ);
    add(0, 13, 0, 1, E_FETCH, S_LJ);
    add(0, 13, 0, 0, E_NONE, S_LJ);
    add(0, 13, 0, 0, E_NONE, S_I);
    add(0, 13, 0, 0, E_WB, S_I);
    add(0, 35, 0, 1, E_FETCH, S_I);
    add(0, 35, 0, 1, E_NONE, S_I);
    add(0, 35, 0, 1, E_NONE, S_LJ);
    add(0, 35, 0, 0, E_RD, S_LJ);
    add(1, 35, 0, 1, E_NONE, S_0);
    add(0, 35, 0, 1, E_NONE, S_0);
    add(0, 35, 0, 0, E_WAIT, S_R);
    foreach (tv[i]) step($sformatf("vec%0d", i), tv[i].r, tv[i].op, tv[i].z, tv[i].mr, tv[i].en, tv[i].sel);
    step("sw_rst", 1, 43, 0, 0, E_NONE, S_0);
    step("sw_start", 0, 43, 0, 0, E_NONE, S_0);
    step("sw_fetch", 0, 43, 0, 1, E_FETCH, S_R);
    step("sw_decode", 0, 43, 0, 1, E_NONE, S_R);
    step("sw_exec", 0, 43, 0, 1, E_NONE, S_I);
`ifdef CTRL_MEM_WATCHDOG_EN
    for (int i = 0; i < 4; i++) step($sformatf("wd_wait%0d", i), 0, 43, 0, 0, E_WR, S_I);
    for (int i = 0; i < 3; i++) step($sformatf("wd_fault%0d", i), 0, 43, 0, 1, E_FLT, S_I);
    step("wd_rst", 1, 43, 0, 1, E_NONE, S_0);
    step("wd2_start", 0, 43, 0, 1, E_NONE, S_0);
    step("wd2_fetch", 0, 43, 0, 1, E_FETCH, S_R);
    step("wd2_decode", 0, 43, 0, 1, E_NONE, S_R);
    step("wd2_exec", 0, 43, 0, 1, E_NONE, S_I);
    for (int i = 0; i < 3; i++) step($sformatf("wd2_wait%0d", i), 0, 43, 0, 0, E_WR, S_I);
    step("wd2_ready", 0, 43, 0, 1, E_WR, S_I);
    step("wd2_next", 0, 43, 0, 0, E_WAIT, S_I);
`else
    for (int i = 0; i < 20; i++) step($sformatf("long_wait%0d", i), 0, 43, 0, 0, E_WR, S_I);
    step("long_ready", 0, 43, 0, 1, E_WR, S_I);
    step("long_next", 0, 43, 0, 0, E_WAIT, S_I);
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
